sprite_pattern_responder: RTL and testbench

// - Serves sprite pattern-row fetch requests (13-bit addr {tile_y,tile_x,tile_row}) against the pattern RAM.
// - Sits between the sprite engine's address generation and the synchronous pattern RAM read port.
// - Issues one RAM read per accepted request and tracks reads in flight.
// - Buffers returned rows in a FIFO so the sprite engine may backpressure without losing data.

---
 rtl/sprite_pattern_responder_if.sv | 25 ++
 rtl/sprite_pattern_responder.sv | 116 +++++++++++
 tb/tb_sprite_pattern_responder.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_pattern_responder_if.sv
// Request/response handshake bundle between the sprite engine and the pattern-row responder.
interface sprite_pattern_responder_if #(
  parameter int ADDR_W = 13,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [1:0]        req_tag;
  logic              req_xmirror;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic [1:0]        rsp_tag;

  modport master (
    output req_valid, req_addr, req_tag, req_xmirror, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_tag
  );

  modport slave (
    input  req_valid, req_addr, req_tag, req_xmirror, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_tag
  );
endinterface

// File: rtl/sprite_pattern_responder.sv
// Pattern-row fetch responder: one RAM read per request, show-ahead response FIFO with credit-style occupancy.
// Optional horizontal nibble mirroring is enabled by defining SPRITE_PATTERN_XMIRROR_EN.
module sprite_pattern_responder #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 32,
  parameter int RAM_LAT    = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  sprite_pattern_responder_if.slave bus,
  output logic                ram_rd_en,
  output logic [ADDR_W-1:0]   ram_addr,
  input  logic [DATA_W-1:0]   ram_rd_data,
  output logic                busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic [CNT_W-1:0]  occ;
  logic [CNT_W-1:0]  fifo_cnt;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] mem_data [FIFO_DEPTH];
  logic [1:0]        mem_tag  [FIFO_DEPTH];
  logic [RAM_LAT-1:0] pipe_valid;
  logic [1:0]        pipe_tag [RAM_LAT];
  logic              accept;
  logic              pop;
  logic              fifo_wr;
  logic [DATA_W-1:0] wr_data;

  // Occupancy counts in-flight reads too, so a full count means the FIFO can never overflow.
  assign bus.req_ready = (occ < CNT_W'(FIFO_DEPTH)) && !rst;
  assign accept        = bus.req_valid && bus.req_ready;
  assign ram_rd_en     = accept;
  assign ram_addr      = bus.req_addr;
  assign bus.rsp_valid = (fifo_cnt != '0);
  assign pop           = bus.rsp_valid && bus.rsp_ready;
  assign fifo_wr       = pipe_valid[RAM_LAT-1];
  assign bus.rsp_data  = bus.rsp_valid ? mem_data[rd_ptr] : '0;
  assign bus.rsp_tag   = bus.rsp_valid ? mem_tag[rd_ptr]  : 2'd0;
  assign busy          = (occ != '0);

`ifdef SPRITE_PATTERN_XMIRROR_EN
  logic [RAM_LAT-1:0] pipe_mirror;

  function automatic logic [DATA_W-1:0] nibble_reverse(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = d[4*(7-i) +: 4];
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_mirror <= '0;
    end else begin
      pipe_mirror[0] <= bus.req_xmirror;
      for (int k = 1; k < RAM_LAT; k++) pipe_mirror[k] <= pipe_mirror[k-1];
    end
  end

  assign wr_data = pipe_mirror[RAM_LAT-1] ? nibble_reverse(ram_rd_data) : ram_rd_data;
`else
  logic unused_xmirror;
  assign unused_xmirror = bus.req_xmirror;
  assign wr_data        = ram_rd_data;
`endif

  // Read pipeline never stalls; clearing it on reset drops data for pre-reset reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      for (int k = 0; k < RAM_LAT; k++) pipe_tag[k] <= 2'd0;
    end else begin
      pipe_valid[0] <= accept;
      pipe_tag[0]   <= bus.req_tag;
      for (int k = 1; k < RAM_LAT; k++) begin
        pipe_valid[k] <= pipe_valid[k-1];
        pipe_tag[k]   <= pipe_tag[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= '0;
      fifo_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   occ <= occ + CNT_W'(1);
        2'b01:   occ <= occ - CNT_W'(1);
        default: occ <= occ;
      endcase
      case ({fifo_wr, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (fifo_wr) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_wr) begin
      mem_data[wr_ptr] <= wr_data;
      mem_tag[wr_ptr]  <= pipe_tag[RAM_LAT-1];
    end
  end

endmodule

// File: tb/tb_sprite_pattern_responder.sv
// Scoreboard bench for sprite_pattern_responder with a 2-cycle-latency pattern RAM model.
module tb_sprite_pattern_responder;
  logic        clk;
  logic        rst;
  logic        ram_rd_en;
  logic [12:0] ram_addr;
  logic [31:0] ram_rd_data;
  logic        busy;

  sprite_pattern_responder_if #(.ADDR_W(13), .DATA_W(32)) bus ();

  sprite_pattern_responder #(.ADDR_W(13), .DATA_W(32), .RAM_LAT(2), .FIFO_DEPTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .ram_rd_en   (ram_rd_en),
    .ram_addr    (ram_addr),
    .ram_rd_data (ram_rd_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [33:0] sb_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] ram_word(input logic [12:0] a);
    if (a == 13'h0123) return 32'h89ABCDEF;
    if (a == 13'h0456) return 32'h76543210;
    return {a, ~a[5:0], a};
  endfunction

  function automatic logic [31:0] mirror_ref(input logic [31:0] d);
    logic [31:0] r;
    for (int i = 0; i < 8; i++) r[4*i +: 4] = d[28-4*i +: 4];
    return r;
  endfunction

  // RAM model: address registered twice, data valid two cycles after the strobe
  logic [12:0] ra1, ra2;
  always @(posedge clk) begin
    ra1 <= ram_addr;
    ra2 <= ra1;
  end
  assign ram_rd_data = ram_word(ra2);

  // Scoreboard monitor, sampled mid-cycle
  always @(negedge clk) begin
    logic [31:0] w;
    logic [33:0] e;
    if (!rst && bus.req_valid && bus.req_ready) begin
      w = ram_word(bus.req_addr);
`ifdef SPRITE_PATTERN_XMIRROR_EN
      if (bus.req_xmirror) w = mirror_ref(w);
`endif
      sb_q.push_back({bus.req_tag, w});
    end
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("sb_data", 64'(bus.rsp_data), 64'(e[31:0]));
        check("sb_tag",  64'(bus.rsp_tag),  64'(e[33:32]));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 60 && busy; i++) tick();
    check("drain_busy", 64'(busy), 64'd0);
  endtask

  task automatic send(input logic [12:0] a, input logic [1:0] t, input logic m);
    bus.req_valid   = 1'b1;
    bus.req_addr    = a;
    bus.req_tag     = t;
    bus.req_xmirror = m;
  endtask

  initial begin
    int n_acc;
    int cyc;
    rst             = 1'b1;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_tag     = '0;
    bus.req_xmirror = 1'b0;
    bus.rsp_ready   = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    check("rst_req_ready", 64'(bus.req_ready), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_data",  64'(bus.rsp_data),  64'd0);
    check("rst_rsp_tag",   64'(bus.rsp_tag),   64'd0);
    check("rst_ram_rd_en", 64'(ram_rd_en),     64'd0);
    check("rst_busy",      64'(busy),          64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 64'(bus.req_ready), 64'd1);

    // Single read, response three cycles after accept
    tick();
    bus.rsp_ready = 1'b1;
    send(13'h0123, 2'd2, 1'b0);
    @(negedge clk);
    check("single_rd_en", 64'(ram_rd_en), 64'd1);
    check("single_addr",  64'(ram_addr),  64'h0123);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("single_c1_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_c2_valid", 64'(bus.rsp_valid), 64'd0);
    tick();
    @(negedge clk);
    check("single_c3_valid", 64'(bus.rsp_valid), 64'd1);
    check("single_c3_data",  64'(bus.rsp_data),  64'h89ABCDEF);
    check("single_c3_tag",   64'(bus.rsp_tag),   64'd2);
    tick();
    drain();

    // Backpressure: six back-to-back requests, only four accepted
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      send(13'h0200 + 13'(i), 2'(i), 1'b0);
      @(negedge clk);
      check("bp_req_ready", 64'(bus.req_ready), 64'(i < 4));
      check("bp_rd_en",     64'(ram_rd_en),     64'(i < 4));
      tick();
    end
    bus.req_valid = 1'b0;
    repeat (3) tick();
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_full_valid", 64'(bus.rsp_valid), 64'd1);
    check("bp_pop_ready",  64'(bus.req_ready), 64'd0);
    tick();
    @(negedge clk);
    check("bp_after_pop_ready", 64'(bus.req_ready), 64'd1);
    tick();
    drain();

    // Full plus simultaneous accept and pop
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(13'h0280 + 13'(i), 2'(i), 1'b0);
      tick();
    end
    repeat (3) tick();
    @(negedge clk);
    check("full_ready", 64'(bus.req_ready), 64'd0);
    tick();
    bus.rsp_ready = 1'b1;
    n_acc = 0;
    cyc   = 0;
    while (n_acc < 20 && cyc < 60) begin
      send(13'h0300 + 13'(n_acc), 2'(n_acc), 1'b0);
      @(negedge clk);
      if (bus.req_ready) n_acc++;
      cyc++;
      tick();
    end
    bus.req_valid = 1'b0;
    check("full_accepts", 64'(n_acc), 64'd20);
    check("full_cycles",  64'(cyc),   64'd21);
    drain();

    // Mirror request
    send(13'h0456, 2'd1, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("mirror_valid", 64'(bus.rsp_valid), 64'd1);
`ifdef SPRITE_PATTERN_XMIRROR_EN
    check("mirror_data", 64'(bus.rsp_data), 64'h01234567);
`else
    check("mirror_data", 64'(bus.rsp_data), 64'h76543210);
`endif
    tick();
    bus.req_xmirror = 1'b0;
    drain();

    // Reset with two reads in flight
    send(13'h0500, 2'd0, 1'b0);
    tick();
    send(13'h0501, 2'd1, 1'b0);
    tick();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("midrst_busy",      64'(busy),          64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      check("midrst_stale_valid", 64'(bus.rsp_valid), 64'd0);
      check("midrst_stale_busy",  64'(busy),          64'd0);
    end

    // Idle
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("idle_rd_en", 64'(ram_rd_en),     64'd0);
      check("idle_valid", 64'(bus.rsp_valid), 64'd0);
      check("idle_busy",  64'(busy),          64'd0);
    end

    check("sb_leftover", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
